spm_seq_io: RTL and testbench
=============================

Name: spm_seq_io

Overview:
- Operand sequencer and product collector wrapped around the serial-parallel multiplier (spm) array.
- Accepts a parallel signed x/y operand pair over a valid/ready handshake and holds x on the array's parallel input.
- Streams y into the array LSB-first with sign extension, and deserializes the serial product bit stream into a 2*WIDTH-bit result.
- Presents the result on a valid/ready output handshake. Sits directly upstream (y, x, clear) and downstream (p) of the csa cell chain.

Parameters:
- WIDTH, 32, operand width; equals the number of csa cells in the spm array.
- P_LAT, 1, cycles from a y bit entering the array to the corresponding p bit appearing on spm_p.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_x  input  WIDTH  multiplicand, signed two's complement.
- in_y  input  WIDTH  multiplier, signed two's complement.
- spm_x  output  WIDTH  parallel operand to the array.
- spm_y  output  1  serial multiplier bit to the array.
- spm_clr  output  1  one-cycle clear pulse for the array's carry/sum state.
- spm_p  input  1  serial product bit from the array.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_prod  output  2*WIDTH  signed product.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; spm_x=0, spm_y=0, spm_clr=0.
  - out_valid=0, out_prod=0, busy=0, cycle counter=0, y shift register=0.
  - in_ready=1 once reset is released.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_x into spm_x and in_y into the y shift register; go to CLEAR.
- CLEAR (exactly 1 cycle):
  - spm_clr=1, spm_y=0, counter cleared to 0.
  - Go to RUN.
- RUN (exactly 2*WIDTH+P_LAT cycles, counter c=0..2*WIDTH+P_LAT-1):
  - spm_y = y[c] for c<WIDTH.
  - spm_y = y[WIDTH-1] (sign extension) for WIDTH<=c<2*WIDTH.
  - spm_y = 0 for c>=2*WIDTH.
  - For c>=P_LAT: product register shifts right one bit and spm_p is inserted at the MSB, giving exactly 2*WIDTH captures.
  - After the last cycle, go to DONE.
- DONE:
  - out_valid=1; out_prod is stable and equals the captured register.
  - On out_ready go to IDLE; with out_ready held high, DONE lasts 1 cycle.
- Outputs are registered; combinational in->out paths are limited to in_ready, which is a function of state.
- Latency: handshake accepted at edge T → CLEAR in cycle T+1 → RUN in cycles T+2 .. T+1+2*WIDTH+P_LAT → out_valid at cycle T+2+2*WIDTH+P_LAT.
- spm_x holds its value from accept until the next accept; it is not cleared at DONE.
- in_valid while busy: ignored, in_ready=0, no operand lost. The upstream must hold its data, per the valid/ready rule.
- Product arithmetic: full signed 2*WIDTH-bit result, no truncation.
  - -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), which is representable.
- Counter width: $clog2(2*WIDTH+P_LAT+1).
- Reset mid-operation (any state): immediate return to the reset values above.
  - The partial product is discarded and out_valid is never raised for the aborted operation.
- out_ready asserted outside DONE: no effect.
- out_prod is not updated in IDLE or CLEAR; it changes only during RUN shifts.

Test Plan (bench uses WIDTH=8, P_LAT=1 and a behavioural spm model with one-cycle p latency):
- Accept x=3, y=5 at edge T → spm_clr high exactly in cycle T+1; out_valid at T+19; out_prod=16'h000F.
- x=-1 (8'hFF), y=-1 (8'hFF) → out_prod=16'h0001; spm_y reads 1 for all 16 stream cycles, then 0.
- x=-128 (8'h80), y=127 (8'h7F) → out_prod=16'hC080 (-16256). Also x=-128, y=-128 → 16'h4000.
- out_ready held low for 5 cycles in DONE → out_valid and out_prod stable throughout, in_ready=0, busy=1. On out_ready=1 → IDLE next cycle; a new operand is accepted the following cycle.
- in_valid pulsed with x=7, y=9 during RUN of 2*3 → ignored; only out_prod=16'h0006 is produced, then IDLE.
- rst driven low at RUN c=6 → all outputs 0 asynchronously. After release, 4*4 → out_prod=16'h0010 with nominal latency and no stale bits.

Source files
------------

// File: rtl/spm_seq_io.sv
// Operand sequencer and product collector for the serial-parallel multiplier array:
// loads x/y, streams sign-extended y LSB-first, and deserializes the serial product.
module spm_seq_io #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned P_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    output logic [WIDTH-1:0]     spm_x,
    output logic                 spm_y,
    output logic                 spm_clr,
    input  logic                 spm_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy
);
    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned RUN_LEN = PW + P_LAT;
    localparam int unsigned CW      = $clog2(RUN_LEN + 1);

    localparam logic [CW-1:0] LAST_C  = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] LAST_Y  = CW'(PW - 1);
    localparam logic [CW-1:0] FIRST_P = CW'(P_LAT);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] y_sr;

    // Acceptance depends only on the registered state.
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            y_sr      <= '0;
            spm_x     <= '0;
            spm_y     <= 1'b0;
            spm_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            busy      <= 1'b0;
        end else begin
            spm_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        spm_x   <= in_x;
                        y_sr    <= in_y;
                        cnt     <= '0;
                        spm_y   <= 1'b0;
                        spm_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    spm_y <= y_sr[0];
                    y_sr  <= WIDTH'($signed(y_sr) >>> 1);
                    state <= RUN;
                end
                RUN: begin
                    // Arithmetic shift keeps presenting the sign bit once y is exhausted.
                    if (cnt >= FIRST_P) begin
                        out_prod <= {spm_p, out_prod[PW-1:1]};
                    end
                    spm_y <= (cnt < LAST_Y) ? y_sr[0] : 1'b0;
                    y_sr  <= WIDTH'($signed(y_sr) >>> 1);
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_C) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spm_seq_io.sv
// Bench for spm_seq_io: behavioural serial multiplier array, queued expected products,
// decoupled monitor comparing each delivered product and its latency.
module tb_spm_seq_io;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 16;
    localparam int          LAT = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x, in_y;
    logic [W-1:0]  spm_x;
    logic          spm_y, spm_clr, spm_p;
    logic          out_valid, out_ready;
    logic [PW-1:0] out_prod;
    logic          busy;

    typedef struct {
        logic [PW-1:0] prod;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic          prev_valid = 1'b0;
    logic [PW-1:0] held;
    logic          rand_rdy = 1'b0;

    spm_seq_io #(.WIDTH(W), .P_LAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .spm_x(spm_x), .spm_y(spm_y),
        .spm_clr(spm_clr), .spm_p(spm_p), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Array model: p bit k is bit k of x times the y bits streamed so far, one cycle later.
    int            k;
    logic [PW-1:0] ybits;
    logic [31:0]   pp;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            k = 0; ybits = '0; spm_p <= 1'b0;
        end else if (spm_clr) begin
            k = 0; ybits = '0; spm_p <= 1'b0;
        end else if (k < PW) begin
            ybits[k] = spm_y;
            pp = 32'($signed(spm_x)) * {16'b0, ybits};
            spm_p <= pp[k];
            k++;
        end else begin
            spm_p <= 1'b0;
        end
    end

    // Monitor: latency on rising out_valid, stability while held, product on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", 64'(1), 64'(0));
                else chk("latency", 64'(cyc - exp_q[0].acc), 64'(LAT));
                held = out_prod;
            end else if (out_valid) begin
                chk("prod_stable", 64'(out_prod), 64'(held));
                chk("in_ready_in_done", 64'(in_ready), 64'(0));
                chk("busy_in_done", 64'(busy), 64'(1));
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                chk("product", 64'(out_prod), 64'(exp_q[0].prod));
                void'(exp_q.pop_front());
            end
            prev_valid = out_valid;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Call only at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        in_x = x; in_y = y; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", 64'(0), 64'(1));
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back('{prod: PW'(int'($signed(x)) * int'($signed(y))), acc: cyc});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 500) begin @(posedge clk); #1; n++; end
        chk("drain_timeout", 64'(n < 500), 64'(1));
    endtask

    initial begin
        int b;
        rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spm_x", 64'(spm_x), 64'(0));
        chk("rst_spm_y", 64'(spm_y), 64'(0));
        chk("rst_spm_clr", 64'(spm_clr), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_prod", 64'(out_prod), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'(1));

        // 3*5 with clear-pulse timing
        send(8'd3, 8'd5);
        @(negedge clk);
        chk("clr_in_clear", 64'(spm_clr), 64'(1));
        chk("spm_y_in_clear", 64'(spm_y), 64'(0));
        chk("busy_in_clear", 64'(busy), 64'(1));
        @(negedge clk);
        chk("clr_after_clear", 64'(spm_clr), 64'(0));
        chk("spm_x_loaded", 64'(spm_x), 64'(3));
        wait_idle();

        // -1*-1: sign-extended stream of ones, then zero
        send(8'hFF, 8'hFF);
        @(negedge clk);
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            chk("spm_y_stream", 64'(spm_y), 64'(c < 16 ? 1 : 0));
        end
        wait_idle();

        send(8'h80, 8'h7F);
        wait_idle();
        send(8'h80, 8'h80);
        wait_idle();
        chk("spm_x_held_in_idle", 64'(spm_x), 64'(8'h80));
        chk("prod_max_neg_sq", 64'(out_prod), 64'(16'h4000));

        // Back-pressure in DONE
        out_ready = 1'b0;
        send(8'd100, 8'hFD);
        b = 0;
        while (!out_valid && b < 100) begin @(negedge clk); b++; end
        chk("done_reached", 64'(out_valid), 64'(1));
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_prod", 64'(out_prod), 64'(16'hFED4));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_out_valid", 64'(out_valid), 64'(0));
        b = cyc;
        send(8'hF9, 8'd11);
        chk("accept_next_cycle", 64'(exp_q[exp_q.size()-1].acc), 64'(b + 1));
        wait_idle();

        // in_valid while busy is ignored
        send(8'd2, 8'd3);
        repeat (5) @(posedge clk);
        #1;
        in_x = 8'd7; in_y = 8'd9; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("in_ready_busy", 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
        chk("spm_x_not_overwritten", 64'(spm_x), 64'(2));
        chk("prod_2x3", 64'(out_prod), 64'(16'h0006));

        // Reset in RUN at c=6
        send(8'h5A, 8'hC3);
        @(negedge clk);
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_spm_x", 64'(spm_x), 64'(0));
        chk("arst_spm_y", 64'(spm_y), 64'(0));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_out_prod", 64'(out_prod), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        send(8'd4, 8'd4);
        wait_idle();
        chk("prod_after_abort", 64'(out_prod), 64'(16'h0010));

        // Randomized operands with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #0;
        end
        wait_idle();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
